// File: rtl/any1_branch_issue.sv
// In-order branch issue queue for the ANY-1 core: buffers dispatched branches, wakes
// their operands from the CDB and resolves the head entry into a registered result.

module any1_eval_branch #(
  parameter int WID = 64
) (
  input  logic [63:0]    inst_i,
  input  logic [WID-1:0] a_i,
  input  logic [WID-1:0] b_i,
  output logic           takb_o
);
  localparam logic [7:0] OP_BEQ  = 8'h40;
  localparam logic [7:0] OP_BNE  = 8'h41;
  localparam logic [7:0] OP_BLT  = 8'h44;
  localparam logic [7:0] OP_BGE  = 8'h45;
  localparam logic [7:0] OP_BLTU = 8'h46;
  localparam logic [7:0] OP_BGEU = 8'h47;

  logic [7:0] opcode;
  logic       unused_inst;

  assign opcode      = inst_i[7:0];
  assign unused_inst = ^inst_i[63:8];

  always_comb begin
    case (opcode)
      OP_BEQ:  takb_o = (a_i == b_i);
      OP_BNE:  takb_o = (a_i != b_i);
      OP_BLT:  takb_o = ($signed(a_i) <  $signed(b_i));
      OP_BGE:  takb_o = ($signed(a_i) >= $signed(b_i));
      OP_BLTU: takb_o = (a_i <  b_i);
      OP_BGEU: takb_o = (a_i >= b_i);
      default: takb_o = 1'b0;
    endcase
  end
endmodule

module any1_branch_issue #(
  parameter int DEPTH = 4,
  parameter int WID   = 64,
  parameter int TAGW  = 5,
  parameter int AWID  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     disp_valid_i,
  output logic                     disp_ready_o,
  input  logic [63:0]              disp_inst_i,
  input  logic [TAGW-1:0]          disp_tag_i,
  input  logic [WID-1:0]           disp_a_i,
  input  logic [WID-1:0]           disp_b_i,
  input  logic                     disp_av_i,
  input  logic                     disp_bv_i,
  input  logic [TAGW-1:0]          disp_atag_i,
  input  logic [TAGW-1:0]          disp_btag_i,
  input  logic [AWID-1:0]          disp_tgt_i,
  input  logic                     cdb_valid_i,
  input  logic [TAGW-1:0]          cdb_tag_i,
  input  logic [WID-1:0]           cdb_data_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [TAGW-1:0]          res_tag_o,
  output logic                     res_takb_o,
  output logic [AWID-1:0]          res_tgt_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic [63:0]     inst;
    logic [TAGW-1:0] tag;
    logic [WID-1:0]  a;
    logic            av;
    logic [TAGW-1:0] atag;
    logic [WID-1:0]  b;
    logic            bv;
    logic [TAGW-1:0] btag;
    logic [AWID-1:0] tgt;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic            res_valid_q, res_valid_d;
  logic            res_takb_q, res_takb_d;
  logic [TAGW-1:0] res_tag_q, res_tag_d;
  logic [AWID-1:0] res_tgt_q, res_tgt_d;

  entry_t head_ent, disp_ent;
  logic   disp_fire, issue, eval_takb;

  assign disp_ready_o = (count_q != CNT_FULL);
  assign disp_fire    = disp_valid_i && disp_ready_o;
  assign head_ent     = ent_q[head_q];
  assign issue        = (count_q != '0) && head_ent.av && head_ent.bv &&
                        (!res_valid_q || res_ready_i);

  any1_eval_branch #(.WID(WID)) u_eval (
    .inst_i (head_ent.inst),
    .a_i    (head_ent.a),
    .b_i    (head_ent.b),
    .takb_o (eval_takb)
  );

  // A dispatching operand whose producer broadcasts this very cycle is captured on entry.
  always_comb begin
    disp_ent.inst = disp_inst_i;
    disp_ent.tag  = disp_tag_i;
    disp_ent.atag = disp_atag_i;
    disp_ent.btag = disp_btag_i;
    disp_ent.tgt  = disp_tgt_i;
    disp_ent.a    = disp_a_i;
    disp_ent.av   = disp_av_i;
    disp_ent.b    = disp_b_i;
    disp_ent.bv   = disp_bv_i;
    if (!disp_av_i && cdb_valid_i && (disp_atag_i == cdb_tag_i)) begin
      disp_ent.a  = cdb_data_i;
      disp_ent.av = 1'b1;
    end
    if (!disp_bv_i && cdb_valid_i && (disp_btag_i == cdb_tag_i)) begin
      disp_ent.b  = cdb_data_i;
      disp_ent.bv = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned (no latch).
    ent_d       = ent_q;
    vld_d       = vld_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    res_takb_d  = res_takb_q;
    res_tag_d   = res_tag_q;
    res_tgt_d   = res_tgt_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && cdb_valid_i) begin
        if (!ent_q[i].av && (ent_q[i].atag == cdb_tag_i)) begin
          ent_d[i].a  = cdb_data_i;
          ent_d[i].av = 1'b1;
        end
        if (!ent_q[i].bv && (ent_q[i].btag == cdb_tag_i)) begin
          ent_d[i].b  = cdb_data_i;
          ent_d[i].bv = 1'b1;
        end
      end
    end

    if (issue) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_ONE;
      res_valid_d   = 1'b1;
      res_takb_d    = eval_takb;
      res_tag_d     = head_ent.tag;
      res_tgt_d     = head_ent.tgt;
    end else if (res_ready_i) begin
      res_valid_d   = 1'b0;
    end

    if (disp_fire) begin
      ent_d[tail_q] = disp_ent;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PTR_ONE;
    end

    case ({disp_fire, issue})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      vld_d       = '0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      res_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_takb_q  <= 1'b0;
      res_tag_q   <= '0;
      res_tgt_q   <= '0;
    end else begin
      vld_q       <= vld_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_takb_q  <= res_takb_d;
      res_tag_q   <= res_tag_d;
      res_tgt_q   <= res_tgt_d;
    end
  end

  // NOTE: entry payload is not reset; vld_q and count_q alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

  assign res_valid_o = res_valid_q;
  assign res_takb_o  = res_takb_q;
  assign res_tag_o   = res_tag_q;
  assign res_tgt_o   = res_tgt_q;
  assign count_o     = count_q;
endmodule
